// File: rtl/dsp_top.sv
// Single-cycle Harvard 16-bit fixed-point DSP core: ACC(32), T(16), P(16), private I/D memories.
// Build option DSP_SAT_EN: ADD/SUB/APAC/SPAC saturate the accumulator instead of wrapping.

module dsp_reg #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);
  always_ff @(posedge clk or posedge rst)
    if (rst) q <= '0;
    else     q <= d;
endmodule

module dsp_acc (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] d,
  output logic [31:0] out
);
  always_ff @(posedge clk or posedge rst)
    if (rst) out <= '0;
    else     out <= d;
endmodule

module dsp_mem #(
  parameter int DEPTH = 1024,
  parameter int AW    = 10
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          we,
  input  logic [AW-1:0] addr,
  input  logic [15:0]   wdata,
  output logic [15:0]   rdata
);
  logic [15:0] mem [DEPTH];

  // A reset coinciding with the edge aborts the store of the in-flight instruction.
  always_ff @(posedge clk)
    if (we && !rst) mem[addr] <= wdata;

  assign rdata = mem[addr];
endmodule

module dsp_top #(
  parameter int IMEM_DEPTH = 1024,
  parameter int DMEM_DEPTH = 1024
) (
  input  logic        clk,
  input  logic        reset,
  output logic [11:0] pc,
  output logic [31:0] acc,
  output logic        halted
);
  localparam int IAW = (IMEM_DEPTH > 1) ? $clog2(IMEM_DEPTH) : 1;
  localparam int DAW = (DMEM_DEPTH > 1) ? $clog2(DMEM_DEPTH) : 1;

  typedef enum logic [3:0] {
    OP_NOP, OP_LAC, OP_ADD, OP_SUB, OP_LT, OP_MPY, OP_APAC, OP_SPAC,
    OP_PAC, OP_SACL, OP_SACH, OP_ZAC, OP_B, OP_BZ, OP_LACK, OP_HALT
  } op_e;

  logic [11:0]    pc_q, pc_d, pc_inc, br_tgt;
  logic           halted_q, halted_d;
  logic [31:0]    acc_q, acc_d, m_sext, p_sext, prod;
  logic [15:0]    t_q, t_d, p_q, p_d;
  logic [15:0]    instr, mdata, dm_wdata;
  logic [11:0]    opnd;
  logic [3:0]     opcode;
  logic [DAW-1:0] daddr;
  logic           dm_we;

  dsp_mem #(.DEPTH(IMEM_DEPTH), .AW(IAW)) InstrMem (
    .clk(clk), .rst(reset), .we(1'b0), .addr(IAW'(pc_q)), .wdata(16'h0000), .rdata(instr)
  );

  dsp_mem #(.DEPTH(DMEM_DEPTH), .AW(DAW)) DataMem (
    .clk(clk), .rst(reset), .we(dm_we), .addr(daddr), .wdata(dm_wdata), .rdata(mdata)
  );

  dsp_acc Accumulator (.clk(clk), .rst(reset), .d(acc_d), .out(acc_q));
  dsp_reg #(.W(16)) T (.clk(clk), .rst(reset), .d(t_d), .q(t_q));
  dsp_reg #(.W(16)) P (.clk(clk), .rst(reset), .d(p_d), .q(p_q));

  assign opcode = instr[15:12];
  assign opnd   = instr[11:0];
  assign daddr  = DAW'(opnd % DMEM_DEPTH);
  assign br_tgt = 12'(opnd % IMEM_DEPTH);
  assign pc_inc = (pc_q == 12'(IMEM_DEPTH - 1)) ? 12'd0 : pc_q + 12'd1;
  assign m_sext = {{16{mdata[15]}}, mdata};
  assign p_sext = {{16{p_q[15]}}, p_q};
  // Low 32 bits of the unsigned product of sign-extended operands equal the signed product.
  assign prod   = {{16{t_q[15]}}, t_q} * m_sext;

  function automatic logic [31:0] acc_arith(input logic [31:0] a, input logic [31:0] b,
                                            input logic sub);
    logic [32:0] s;
    s = sub ? ({a[31], a} - {b[31], b}) : ({a[31], a} + {b[31], b});
`ifdef DSP_SAT_EN
    if (s[32] != s[31]) return s[32] ? 32'h8000_0000 : 32'h7FFF_FFFF;
`endif
    return s[31:0];
  endfunction

  always_comb begin
    pc_d     = pc_inc;
    halted_d = halted_q;
    acc_d    = acc_q;
    t_d      = t_q;
    p_d      = p_q;
    dm_we    = 1'b0;
    dm_wdata = 16'h0000;
    if (halted_q) begin
      pc_d = pc_q;
    end else begin
      // Unknown opcodes fall through to default and behave as NOP.
      case (opcode)
        OP_LAC:  acc_d = m_sext;
        OP_ADD:  acc_d = acc_arith(acc_q, m_sext, 1'b0);
        OP_SUB:  acc_d = acc_arith(acc_q, m_sext, 1'b1);
        OP_LT:   t_d   = mdata;
        OP_MPY:  p_d   = prod[30:15];
        OP_APAC: acc_d = acc_arith(acc_q, p_sext, 1'b0);
        OP_SPAC: acc_d = acc_arith(acc_q, p_sext, 1'b1);
        OP_PAC:  acc_d = p_sext;
        OP_SACL: begin dm_we = 1'b1; dm_wdata = acc_q[15:0];  end
        OP_SACH: begin dm_we = 1'b1; dm_wdata = acc_q[31:16]; end
        OP_ZAC:  acc_d = 32'd0;
        OP_B:    pc_d  = br_tgt;
        OP_BZ:   if (acc_q == 32'd0) pc_d = br_tgt;
        OP_LACK: acc_d = {{20{opnd[11]}}, opnd};
        OP_HALT: begin pc_d = pc_q; halted_d = 1'b1; end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      pc_q     <= 12'd0;
      halted_q <= 1'b0;
    end else begin
      pc_q     <= pc_d;
      halted_q <= halted_d;
    end

  assign pc     = pc_q;
  assign acc    = acc_q;
  assign halted = halted_q;
endmodule

// File: tb/tb_dsp_top.sv
// Scoreboard bench for dsp_top: an instruction-level reference model queues the expected
// per-cycle architectural state; a negedge monitor pops and compares.
module tb_dsp_top;
  localparam int ID = 1024;
  localparam int DD = 1024;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [11:0] pc;
  logic [31:0] acc;
  logic        halted;

  dsp_top #(.IMEM_DEPTH(ID), .DMEM_DEPTH(DD)) dut (
    .clk(clk), .reset(reset), .pc(pc), .acc(acc), .halted(halted)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [11:0] pc;
    logic [31:0] acc;
    logic        halted;
  } st_t;

  st_t         exp_q[$];
  int          tests = 0;
  int          fails = 0;
  bit          mon_en = 0;

  logic [15:0] imem_m   [ID];
  logic [15:0] dmem_init[DD];
  logic [15:0] m_dmem   [DD];
  logic [11:0] m_pc;
  logic [31:0] m_acc;
  logic [15:0] m_t, m_p;
  bit          m_halt;

  function automatic logic [15:0] ins(input int op, input int opd);
    logic [15:0] w;
    w = {4'(op), 12'(opd)};
    return w;
  endfunction

  task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s got=%0h exp=%0h", nm, got, exp);
    end
  endtask

  always @(negedge clk) begin
    if (mon_en && exp_q.size() > 0) begin
      st_t e;
      e = exp_q.pop_front();
      tests++;
      if ({pc, acc, halted} !== {e.pc, e.acc, e.halted}) begin
        fails++;
        $display("FAIL trace pc/acc/halted got=%0h/%0h/%0b exp=%0h/%0h/%0b",
                 pc, acc, halted, e.pc, e.acc, e.halted);
      end
    end
  end

  function automatic logic [31:0] fit32(input longint v);
    longint r;
    r = v;
`ifdef DSP_SAT_EN
    if (r > 64'sd2147483647)  r = 64'sd2147483647;
    if (r < -64'sd2147483648) r = -64'sd2147483648;
`endif
    return r[31:0];
  endfunction

  task automatic model_step();
    logic [15:0] w;
    logic [11:0] opd;
    int          op, da, mv, pv, nxt, prodi;
    longint      av;
    if (m_halt) return;
    w   = imem_m[m_pc];
    op  = int'(w[15:12]);
    opd = w[11:0];
    da  = int'(opd) % DD;
    mv  = int'($signed(m_dmem[da]));
    pv  = int'($signed(m_p));
    av  = longint'($signed(m_acc));
    nxt = (int'(m_pc) + 1) % ID;
    case (op)
      1:  m_acc = mv;
      2:  m_acc = fit32(av + mv);
      3:  m_acc = fit32(av - mv);
      4:  m_t = m_dmem[da];
      5:  begin prodi = int'($signed(m_t)) * mv; m_p = 16'(prodi >>> 15); end
      6:  m_acc = fit32(av + pv);
      7:  m_acc = fit32(av - pv);
      8:  m_acc = pv;
      9:  m_dmem[da] = m_acc[15:0];
      10: m_dmem[da] = m_acc[31:16];
      11: m_acc = 0;
      12: nxt = int'(opd) % ID;
      13: if (m_acc == 0) nxt = int'(opd) % ID;
      14: m_acc = int'($signed(opd));
      15: begin m_halt = 1; nxt = int'(m_pc); end
      default: ;
    endcase
    m_pc = 12'(nxt);
  endtask

  task automatic clear_prog();
    for (int i = 0; i < ID; i++) imem_m[i] = 16'h0000;
    for (int i = 0; i < DD; i++) dmem_init[i] = 16'($urandom);
  endtask

  // Runs the loaded program for ncyc clocks from reset; leaves reset low at negedge+1.
  task automatic run_prog(input string nm, input int ncyc, input logic [31:0] init_acc);
    int bad;
    for (int i = 0; i < ID; i++) dut.InstrMem.mem[i] = imem_m[i];
    for (int i = 0; i < DD; i++) begin
      dut.DataMem.mem[i] = dmem_init[i];
      m_dmem[i] = dmem_init[i];
    end
    m_pc = 0; m_acc = init_acc; m_t = 0; m_p = 0; m_halt = 0;
    for (int k = 0; k < ncyc; k++) begin
      model_step();
      exp_q.push_back('{pc: m_pc, acc: m_acc, halted: m_halt});
    end
    @(negedge clk);
    reset = 1'b0;
    if (init_acc != 0) dut.Accumulator.out = init_acc;
    @(posedge clk);
    mon_en = 1;
    for (int k = 0; k < ncyc + 4 && exp_q.size() != 0; k++) begin
      @(negedge clk);
      #1;
    end
    mon_en = 0;
    tests++;
    if (exp_q.size() != 0) begin
      fails++;
      $display("FAIL %s timeout left=%0d exp=0", nm, exp_q.size());
    end
    exp_q.delete();
    chk({nm, "_T"}, dut.T.q, m_t);
    chk({nm, "_P"}, dut.P.q, m_p);
    bad = 0;
    for (int i = 0; i < DD; i++) if (dut.DataMem.mem[i] !== m_dmem[i]) bad++;
    chk({nm, "_dmem_bad_words"}, bad, 0);
  endtask

  // Asynchronous reset with whatever state the last program left behind.
  task automatic reset_chk(input string nm);
    reset = 1'b1;
    #1;
    chk({nm, "_rst_pc"}, pc, 0);
    chk({nm, "_rst_acc"}, acc, 0);
    chk({nm, "_rst_T"}, dut.T.q, 0);
    chk({nm, "_rst_P"}, dut.P.q, 0);
    chk({nm, "_rst_halted"}, halted, 0);
  endtask

  initial begin
    // Load/store with sign extension
    clear_prog();
    dmem_init[5] = 16'h8001;
    imem_m[0] = ins(1, 5); imem_m[1] = ins(9, 6); imem_m[2] = ins(10, 7); imem_m[3] = ins(15, 0);
    run_prog("ldst", 8, 0);
    chk("ldst_dm6", dut.DataMem.mem[6], 16'h8001);
    chk("ldst_dm7", dut.DataMem.mem[7], 16'hFFFF);
    chk("ldst_acc", acc, 32'hFFFF_8001);
    chk("ldst_halted", halted, 1);
    reset_chk("ldst");

    // Multiply-accumulate
    clear_prog();
    dmem_init[0] = 16'h4000; dmem_init[1] = 16'h2000;
    imem_m[0] = ins(4, 0); imem_m[1] = ins(5, 1); imem_m[2] = ins(8, 0);
    imem_m[3] = ins(6, 0); imem_m[4] = ins(15, 0);
    run_prog("mac", 8, 0);
    chk("mac_P", dut.P.q, 16'h1000);
    chk("mac_acc", acc, 32'h0000_2000);
    reset_chk("mac");

    // Branch loop
    clear_prog();
    dmem_init[10] = 16'h0001; dmem_init[11] = 16'h0000;
    imem_m[0] = ins(14, 3);  imem_m[1] = ins(3, 10); imem_m[2] = ins(13, 4); imem_m[3] = ins(12, 1);
    imem_m[4] = ins(11, 0);  imem_m[5] = ins(4, 11); imem_m[6] = ins(5, 11); imem_m[7] = ins(15, 0);
    run_prog("loop", 20, 0);
    chk("loop_acc", acc, 0);
    chk("loop_halted", halted, 1);
    chk("loop_pc", pc, 7);
    reset_chk("loop");

    // Q15 corner: -1.0 * -1.0 slices to 0x8000
    clear_prog();
    dmem_init[0] = 16'h8000;
    imem_m[0] = ins(4, 0); imem_m[1] = ins(5, 0); imem_m[2] = ins(8, 0); imem_m[3] = ins(15, 0);
    run_prog("mpymin", 6, 0);
    chk("mpymin_P", dut.P.q, 16'h8000);
    chk("mpymin_acc", acc, 32'hFFFF_8000);
    reset_chk("mpymin");

    // Signed overflow / underflow of the accumulator
    clear_prog();
    dmem_init[2] = 16'h0001;
    imem_m[0] = ins(2, 2); imem_m[1] = ins(15, 0);
    run_prog("ovf", 4, 32'h7FFF_FFFF);
`ifdef DSP_SAT_EN
    chk("ovf_acc", acc, 32'h7FFF_FFFF);
`else
    chk("ovf_acc", acc, 32'h8000_0000);
`endif
    reset_chk("ovf");
    imem_m[0] = ins(3, 2);
    run_prog("udf", 4, 32'h8000_0000);
`ifdef DSP_SAT_EN
    chk("udf_acc", acc, 32'h8000_0000);
`else
    chk("udf_acc", acc, 32'h7FFF_FFFF);
`endif
    reset_chk("udf");

    // PC wraps from the last instruction word back to 0
    clear_prog();
    imem_m[0] = ins(12, ID - 4);
    run_prog("wrap", 11, 0);
    reset_chk("wrap");

    // Randomised programs
    for (int p = 0; p < 10; p++) begin
      clear_prog();
      for (int i = 0; i < 24; i++) begin
        int op;
        op = $urandom_range(0, 15);
        if (op == 12 || op == 13) imem_m[i] = ins(op, $urandom_range(0, 23));
        else                      imem_m[i] = ins(op, $urandom_range(0, 4095));
      end
      run_prog($sformatf("rand%0d", p), 60, 0);
      reset_chk($sformatf("rand%0d", p));
    end

    // Reset landing on a SACL edge must suppress the store
    clear_prog();
    dmem_init[20] = 16'h5555;
    imem_m[0] = ins(14, 12'h123); imem_m[1] = ins(9, 20); imem_m[2] = ins(15, 0);
    for (int i = 0; i < ID; i++) dut.InstrMem.mem[i] = imem_m[i];
    for (int i = 0; i < DD; i++) dut.DataMem.mem[i] = dmem_init[i];
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    #1;
    chk("midrst_pc_before", pc, 1);
    reset = 1'b1;
    @(posedge clk);
    #1;
    chk("midrst_dm20_kept", dut.DataMem.mem[20], 16'h5555);
    chk("midrst_pc", pc, 0);
    @(negedge clk);
    reset = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    chk("midrst_dm20_rerun", dut.DataMem.mem[20], 16'h0123);
    chk("midrst_halted", halted, 1);
    chk("midrst_pc_end", pc, 2);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
